// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared definitions for the frame-buffer SRAM arbiter.
//   coord_t      - signed pixel coordinate at the default precision
//   in_bounds()  - signed bounds test: 0 <= x < xres and 0 <= y < yres
//   rd_pipe_lat()- request-to-rd_ready latency for a given SRAM latency
package sram_arb_pkg;

    localparam int COORD_PRECISION = 11;
    localparam int DEF_SRAM_LAT    = 3;
    // Address register + SRAM_LAT + output register
    localparam int DEF_PIPE_LAT    = DEF_SRAM_LAT + 2;

    typedef logic signed [COORD_PRECISION:0] coord_t;

    function automatic int rd_pipe_lat(input int sram_lat);
        return sram_lat + 2;
    endfunction

    function automatic logic in_bounds(input int x, input int y,
                                       input int xres, input int yres);
        return (x >= 0) && (x < xres) && (y >= 0) && (y < yres);
    endfunction

endpackage

// File: rtl/sram_arb_rr.sv
// sram_arb_rr: NUM_WR-wide round-robin arbiter.
//   clk, rst_n  - clock, synchronous active-low reset
//   req         - request vector
//   update      - load the pointer with the current grant index
//   grant       - one-hot grant, first requester after the last granted one
//   grant_idx   - binary index of the granted channel (pointer when idle)
// The pointer resets to NUM_WR-1 so channel 0 is searched first.
module sram_arb_rr #(
    parameter int unsigned NUM_WR = 2,
    parameter int          PTR_W  = (NUM_WR > 1) ? $clog2(NUM_WR) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_WR-1:0] req,
    input  logic              update,
    output logic [NUM_WR-1:0] grant,
    output logic [PTR_W-1:0]  grant_idx
);

    logic [PTR_W-1:0] ptr;
    // One spare bit so ptr+i can be wrapped without overflow
    logic [PTR_W:0]   idx;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = ptr;
        idx       = '0;
        found     = 1'b0;
        for (int unsigned i = 1; i <= NUM_WR; i++) begin
            idx = {1'b0, ptr} + (PTR_W+1)'(i);
            if (idx >= (PTR_W+1)'(NUM_WR))
                idx = idx - (PTR_W+1)'(NUM_WR);
            if (!found && req[idx[PTR_W-1:0]]) begin
                found                  = 1'b1;
                grant[idx[PTR_W-1:0]]  = 1'b1;
                grant_idx              = idx[PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            ptr <= PTR_W'(NUM_WR - 1);
        else if (update)
            ptr <= grant_idx;
    end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: frame-buffer SRAM front end. Pipeline reads get a fixed
// latency; free slots go round-robin to gated write channels.
//   clk, rst_n                 - clock, synchronous active-low reset
//   rd_valid, rd_x, rd_y       - read request (signed coordinates)
//   rd_data, rd_ready          - read result, rd_ready pulses SRAM_LAT+2 later
//   wr_valid, wr_enable        - per-channel pending / gate
//   wr_x, wr_y, wr_data        - packed per-channel write request
//   wr_ack                     - one-cycle pulse per consumed write
//   sram_we, sram_addr,
//   sram_wdata, sram_rdata     - sram_interface side
//   drop_count                 - per-channel saturating OOB write drop count
//                                (present only with SRAM_ARB_DROP_COUNT_EN)
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned NUM_WR     = 2,
    parameter int          X_RES      = 800,
    parameter int          Y_RES      = 600,
    parameter int          PRECISION  = 11,
    parameter int          COORD_BITS = 10,
    parameter int          DATA_W     = 16,
    parameter int          SRAM_LAT   = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              rd_valid,
    input  logic signed [PRECISION:0]         rd_x,
    input  logic signed [PRECISION:0]         rd_y,
    output logic [DATA_W-1:0]                 rd_data,
    output logic                              rd_ready,
    input  logic [NUM_WR-1:0]                 wr_valid,
    input  logic [NUM_WR-1:0]                 wr_enable,
    input  logic [NUM_WR*(PRECISION+1)-1:0]   wr_x,
    input  logic [NUM_WR*(PRECISION+1)-1:0]   wr_y,
    input  logic [NUM_WR*DATA_W-1:0]          wr_data,
    output logic [NUM_WR-1:0]                 wr_ack,
`ifdef SRAM_ARB_DROP_COUNT_EN
    output logic [NUM_WR*16-1:0]              drop_count,
`endif
    output logic                              sram_we,
    output logic [2*COORD_BITS-1:0]           sram_addr,
    output logic [DATA_W:0]                   sram_wdata,
    input  logic [DATA_W:0]                   sram_rdata
);

    localparam int CW       = PRECISION + 1;
    localparam int PIPE_LAT = rd_pipe_lat(SRAM_LAT);
    // Stages ahead of the rd_data/rd_ready output register
    localparam int PIPE_LEN = PIPE_LAT - 1;
    localparam int PTR_W    = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

    logic signed [PRECISION:0] wx [NUM_WR];
    logic signed [PRECISION:0] wy [NUM_WR];
    logic [DATA_W-1:0]         wd [NUM_WR];
    logic [NUM_WR-1:0]         wr_inb;
    logic [NUM_WR-1:0]         holdoff;
    logic [NUM_WR-1:0]         eligible;
    logic [NUM_WR-1:0]         req;
    logic [NUM_WR-1:0]         grant;
    logic [PTR_W-1:0]          grant_idx;
    logic                      rd_inb;
    logic                      rd_take;
    logic [PIPE_LEN-1:0]       rd_vpipe;
    logic [PIPE_LEN-1:0]       rd_opipe;
    logic                      unused_rdata_msb;

    assign unused_rdata_msb = sram_rdata[DATA_W];

    always_comb begin
        for (int unsigned i = 0; i < NUM_WR; i++) begin
            wx[i]     = $signed(wr_x[i*CW +: CW]);
            wy[i]     = $signed(wr_y[i*CW +: CW]);
            wd[i]     = wr_data[i*DATA_W +: DATA_W];
            wr_inb[i] = in_bounds(int'(wx[i]), int'(wy[i]), X_RES, Y_RES);
        end
    end

    assign rd_inb   = in_bounds(int'(rd_x), int'(rd_y), X_RES, Y_RES);
    assign rd_take  = rd_valid && rd_inb;
    // holdoff masks the cycle in which the source is still looking at its ack
    assign eligible = wr_valid & wr_enable & ~holdoff;
    assign req      = rd_take ? '0 : eligible;

    sram_arb_rr #(
        .NUM_WR (NUM_WR),
        .PTR_W  (PTR_W)
    ) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .update    (|grant),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data    <= '0;
            rd_ready   <= 1'b0;
            wr_ack     <= '0;
            holdoff    <= '0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            rd_vpipe   <= '0;
            rd_opipe   <= '0;
        end else begin
            sram_we <= 1'b0;
            wr_ack  <= grant;
            holdoff <= grant;

            if (rd_take) begin
                sram_addr <= {rd_x[COORD_BITS-1:0], rd_y[COORD_BITS-1:0]};
            end else if (|grant && wr_inb[grant_idx]) begin
                sram_we    <= 1'b1;
                sram_addr  <= {wx[grant_idx][COORD_BITS-1:0],
                               wy[grant_idx][COORD_BITS-1:0]};
                sram_wdata <= {1'b0, wd[grant_idx]};
            end

            // OOB reads travel the same delay line so latency never changes
            rd_vpipe[0] <= rd_valid;
            rd_opipe[0] <= rd_valid && !rd_inb;
            for (int unsigned k = 1; k < PIPE_LEN; k++) begin
                rd_vpipe[k] <= rd_vpipe[k-1];
                rd_opipe[k] <= rd_opipe[k-1];
            end

            rd_ready <= rd_vpipe[PIPE_LEN-1];
            if (rd_vpipe[PIPE_LEN-1])
                rd_data <= rd_opipe[PIPE_LEN-1] ? '0 : sram_rdata[DATA_W-1:0];
        end
    end

`ifdef SRAM_ARB_DROP_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_WR; i++) begin
                if (grant[i] && !wr_inb[i] && drop_count[i*16 +: 16] != 16'hFFFF)
                    drop_count[i*16 +: 16] <= drop_count[i*16 +: 16] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               rd_valid;
    logic signed [11:0] rd_x, rd_y;
    logic [15:0]        rd_data;
    logic               rd_ready;
    logic [1:0]         wr_valid, wr_enable, wr_ack;
    logic [23:0]        wr_x, wr_y;
    logic [31:0]        wr_data;
    logic               sram_we;
    logic [19:0]        sram_addr;
    logic [16:0]        sram_wdata;
    logic [16:0]        sram_rdata;
`ifdef SRAM_ARB_DROP_COUNT_EN
    logic [31:0]        drop_count;
`endif

    sram_arbiter #(
        .NUM_WR     (2),
        .X_RES      (800),
        .Y_RES      (600),
        .PRECISION  (11),
        .COORD_BITS (10),
        .DATA_W     (16),
        .SRAM_LAT   (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_valid   (rd_valid),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .wr_valid   (wr_valid),
        .wr_enable  (wr_enable),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
`ifdef SRAM_ARB_DROP_COUNT_EN
        .drop_count (drop_count),
`endif
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: data appears 3 cycles after the registered address, and
    // only for cycles that follow an in-bounds read; otherwise junk.
    logic       rd_issue;
    logic [3:0] iss_p = '0;
    logic [19:0] a0 = '0, a1 = '0, a2 = '0;

    assign rd_issue = rd_valid && (rd_x >= 0) && (rd_x < 12'sd800) &&
                      (rd_y >= 0) && (rd_y < 12'sd600);

    function automatic logic [16:0] mem_word(input logic [19:0] a);
        if (a == 20'h02814) return 17'h0ABCD;
        return {1'b0, a[15:0] ^ 16'h3C3C};
    endfunction

    always @(posedge clk) begin
        iss_p <= {iss_p[2:0], rd_issue};
        a0 <= sram_addr;
        a1 <= a0;
        a2 <= a1;
    end

    always @* sram_rdata = iss_p[3] ? mem_word(a2) : 17'h1DEAD;

    // Scoreboard
    typedef struct { int cyc; logic [15:0] data; } rd_exp_t;
    typedef struct {
        int cyc; logic [1:0] ack; logic we; logic [19:0] addr; logic [16:0] wdata;
    } wr_exp_t;

    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];
    rd_exp_t mre;
    wr_exp_t mwe;

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic push_wr(input int c, input logic [1:0] ack, input logic we,
                           input logic [19:0] addr, input logic [16:0] wd);
        wr_q.push_back('{c, ack, we, addr, wd});
    endtask

    // Monitor
    logic       mon_en = 1'b0;
    logic [1:0] prev_ack = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_ready) begin
                if (rd_q.size() == 0) begin
                    chk("rd_unexpected", 64'(rd_ready), 0);
                end else begin
                    mre = rd_q.pop_front();
                    chk("rd_cycle", cyc, mre.cyc);
                    chk("rd_data", rd_data, mre.data);
                end
            end
            if (wr_ack != 2'b00 || sram_we) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", {wr_ack, sram_we}, 0);
                end else begin
                    mwe = wr_q.pop_front();
                    chk("wr_cycle", cyc, mwe.cyc);
                    chk("wr_ack", wr_ack, mwe.ack);
                    chk("sram_we", sram_we, mwe.we);
                    if (mwe.we) begin
                        chk("sram_addr", sram_addr, mwe.addr);
                        chk("sram_wdata", sram_wdata, mwe.wdata);
                    end
                end
                chk("ack_consec", wr_ack & prev_ack, 0);
            end
            prev_ack = wr_ack;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int ch, input int x, input int y, input logic [15:0] d);
        wr_x[ch*12 +: 12]    = 12'(x);
        wr_y[ch*12 +: 12]    = 12'(y);
        wr_data[ch*16 +: 16] = d;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_rd_ready"}, rd_ready, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_wr_ack"}, wr_ack, 0);
        chk({tag, "_sram_we"}, sram_we, 0);
        chk({tag, "_sram_addr"}, sram_addr, 0);
        chk({tag, "_sram_wdata"}, sram_wdata, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    int t0;

    initial begin
        rst_n = 1'b0;
        rd_valid = 1'b0; rd_x = '0; rd_y = '0;
        wr_valid = '0; wr_enable = 2'b11;
        wr_x = '0; wr_y = '0; wr_data = '0;
        repeat (3) tick();
        check_zero_outputs("reset");
        rst_n = 1'b1;
        mon_en = 1'b1;
        tick();

        // In-bounds read (10,20)
        t0 = cyc;
        rd_valid = 1'b1; rd_x = 12'sd10; rd_y = 12'sd20;
        rd_q.push_back('{t0 + 5, 16'hABCD});
        tick();
        rd_valid = 1'b0;
        chk("rd_addr", sram_addr, 20'h02814);
        repeat (6) tick();

        // OOB reads (800,0), (-1,5) with concurrent ch1 write
        t0 = cyc;
        rd_valid = 1'b1; rd_x = 12'sd800; rd_y = 12'sd0;
        set_wr(1, 5, 7, 16'h1111);
        wr_valid = 2'b10;
        rd_q.push_back('{t0 + 5, 16'h0000});
        push_wr(t0 + 1, 2'b10, 1'b1, 20'h01407, 17'h01111);
        tick();
        rd_x = -12'sd1; rd_y = 12'sd5;
        rd_q.push_back('{t0 + 6, 16'h0000});
        tick();
        rd_valid = 1'b0; wr_valid = 2'b00;
        repeat (7) tick();

        // Both channels continuously valid: alternate 0,1,0,1,...
        t0 = cyc;
        set_wr(0, 1, 2, 16'hAAAA);
        set_wr(1, 3, 4, 16'hBBBB);
        wr_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0)
                push_wr(t0 + 1 + k, 2'b01, 1'b1, 20'h00402, 17'h0AAAA);
            else
                push_wr(t0 + 1 + k, 2'b10, 1'b1, 20'h00C04, 17'h0BBBB);
        end
        repeat (6) tick();
        wr_valid = 2'b00;
        repeat (3) tick();

        // Ch1 OOB write (799,600): acked, no SRAM write
        t0 = cyc;
        set_wr(1, 799, 600, 16'hCCCC);
        wr_valid = 2'b10;
        push_wr(t0 + 1, 2'b10, 1'b0, 20'h00000, 17'h00000);
        tick();
`ifdef SRAM_ARB_DROP_COUNT_EN
        chk("drop_count1", drop_count[31:16], 1);
        chk("drop_count0", drop_count[15:0], 0);
`endif
        tick();
        wr_valid = 2'b00;
        repeat (2) tick();

        // Ch0 disabled for 20 cycles, then enabled
        t0 = cyc;
        set_wr(0, 9, 9, 16'h5555);
        wr_valid = 2'b01;
        wr_enable = 2'b10;
        repeat (20) tick();
        wr_enable = 2'b11;
        push_wr(t0 + 21, 2'b01, 1'b1, 20'h02409, 17'h05555);
        tick();
        tick();
        wr_valid = 2'b00;
        repeat (2) tick();

        // Completed read to load rd_data, then reset 2 cycles after a read
        t0 = cyc;
        rd_valid = 1'b1; rd_x = 12'sd10; rd_y = 12'sd20;
        rd_q.push_back('{t0 + 5, 16'hABCD});
        tick();
        rd_valid = 1'b0;
        repeat (5) tick();
        rd_valid = 1'b1; rd_x = 12'sd10; rd_y = 12'sd20;
        tick();
        rd_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check_zero_outputs("midreset");
        rst_n = 1'b1;

        // First grant after reset goes to channel 0
        t0 = cyc;
        set_wr(0, 1, 2, 16'hAAAA);
        set_wr(1, 3, 4, 16'hBBBB);
        wr_valid = 2'b11;
        push_wr(t0 + 1, 2'b01, 1'b1, 20'h00402, 17'h0AAAA);
        push_wr(t0 + 2, 2'b10, 1'b1, 20'h00C04, 17'h0BBBB);
        tick();
        tick();
        wr_valid = 2'b00;
        repeat (8) tick();

        chk("rd_q_empty", rd_q.size(), 0);
        chk("wr_q_empty", wr_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
